alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer that computes unsigned multiply (low/high word), unsigned divide and unsigned remainder by driving the shared 32-bit ALU for 32 iterations. It takes the ALU's operand and control inputs while busy, uses only the ADD and SUB operations, and returns a 32-bit result with a one-cycle done pulse. It sits beside the core datapath; the top level muxes ALU inputs between the datapath and this block using `alu_sel`.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- a  in  32  multiplicand / dividend; captured on accepted start.
- b  in  32  multiplier / divisor; captured on accepted start.
- busy  out  1  high from the cycle after accept until DONE is left.
- done  out  1  one-cycle pulse; `result` is valid in this cycle.
- result  out  32  final value; held until the next accepted start.
- alu_sel  out  1  high in CALC; top level routes `alu_a`/`alu_b`/`alu_ctrl` to the ALU.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_ctrl  out  3  ALU op: 000 ADD, 001 SUB.
- alu_op7b5  out  1  constant 0.
- alu_result  in  32  combinational ALU output, same cycle.
- alu_carry  in  1  ALU SUB borrow: 1 when alu_a < alu_b (unsigned, alu_b ≠ 0).

## Operation
- States: IDLE, CALC, DONE.
  - IDLE → CALC on start.
  - IDLE → DONE on start with op[1]=1 and b=0 (divide by zero).
  - CALC → DONE after iteration 31.
  - DONE → IDLE unconditionally.
- On accept:
  - Latch op, mcand/divisor ← b.
  - MUL: hi ← 0, lo ← a (multiplier).
  - DIV: rem ← 0, quo ← a.
  - cnt ← 0.
- MUL iteration: alu_a=hi, alu_b=mcand, alu_ctrl=ADD.
  - If lo[0]=1: c = (alu_result < hi), computed locally; {hi,lo} ← {c, alu_result, lo} >> 1.
  - Else: {hi,lo} ← {1'b0, hi, lo} >> 1.
- DIV iteration (restoring):
  - Form 33-bit s = {rem, quo[31]}; alu_a = s[31:0], alu_b = divisor, alu_ctrl = SUB.
  - Quotient bit q = s[32] | ~alu_carry.
  - rem ← q ? alu_result : s[31:0]; quo ← {quo[30:0], q}.
- result in DONE: MUL = lo, MULHU = hi, DIVU = quo, REMU = rem.
- Divide by zero: DIVU → 0xFFFFFFFF, REMU → a, with no iterations.
- Outside CALC: alu_sel=0, alu_a=0, alu_b=0, alu_ctrl=000.
- start while busy (CALC or DONE) is ignored and not queued.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, alu_sel 0, all ALU outputs 0, internal registers 0.
- Start accepted at edge E0. CALC occupies cycles E0+1..E0+32, with cnt 0..31. DONE is cycle E0+33.
- Normal latency: done high exactly 33 cycles after the accept edge, for 1 cycle.
- Divide-by-zero latency: DONE in the cycle after accept, so done 1 cycle after accept.
- The earliest next start is sampled in the IDLE cycle after DONE, giving back-to-back throughput of 34 cycles.
- result updates on entry to DONE and holds through IDLE until the next DONE.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, the in-flight result is discarded.
- All ALU-driving outputs are registered-state-derived combinational; the ALU path is combinational within one cycle.

## Structure
- Shared package `alu_pkg` holds:
  - ALU op constants ALU_ADD=3'b000, ALU_SUB=3'b001.
  - MD_MUL/MD_MULHU/MD_DIVU/MD_REMU op codes.
  - The state typedef {IDLE, CALC, DONE}.
- No sub-module. The ALU is instantiated at the top level; the bench instantiates this block plus the ALU and the `alu_sel` mux.

## Test plan
- MUL a=7, b=6 → done at accept+33, result=42; busy high for 33 cycles; done width 1.
- a=0xFFFFFFFF, b=0xFFFFFFFF: MUL → 0x00000001; MULHU → 0xFFFFFFFE.
- DIVU a=100, b=7 → 14; REMU → 2.
- DIVU a=0xFFFFFFFF, b=0x80000001 → 1; REMU → 0x7FFFFFFE (exercises the s[32] path).
- Divide by zero:
  - DIVU a=5, b=0 → 0xFFFFFFFF with done 1 cycle after accept.
  - REMU a=5, b=0 → 5.
- Busy and reset behaviour:
  - start pulsed during CALC → ignored; the original result is unchanged.
  - reset asserted at accept+10 → busy=0, result=0, alu_sel=0.
  - Subsequent MUL 3×5 → 15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/mul-div definitions: ALU op codes, mul/div op codes, sequencer states.
package alu_pkg;
   localparam int WIDTH = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [1:0] MD_MUL   = 2'b00;
   localparam logic [1:0] MD_MULHU = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_REMU  = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;

   // hi holds MULHU/REMU, lo holds MUL/DIVU once the iterations finish
   function automatic logic [WIDTH-1:0] md_pick(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] hi,
                                                 input logic [WIDTH-1:0] lo);
      case (op)
         MD_MULHU, MD_REMU: md_pick = hi;
         default:           md_pick = lo;
      endcase
   endfunction
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU borrow signals of the mul/div sequencer.
interface alu_muldiv_seq_if;
   import alu_pkg::*;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_ctrl;
   logic             alu_op7b5;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   modport master (output start, op, a, b, alu_result, alu_carry,
                   input  busy, done, result, alu_sel, alu_a, alu_b, alu_ctrl, alu_op7b5);
   modport slave  (input  start, op, a, b, alu_result, alu_carry,
                   output busy, done, result, alu_sel, alu_a, alu_b, alu_ctrl, alu_op7b5);
endinterface

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply / restoring divide sequencer that borrows the shared ALU
// for 32 iterations; hi/lo double as rem/quo during division.
module alu_muldiv_seq
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   alu_muldiv_seq_if.slave bus
);
   md_state_t        state, state_nxt;
   logic [1:0]       op_q, op_nxt;
   logic [WIDTH-1:0] hi, hi_nxt, lo, lo_nxt, dvsr, dvsr_nxt;
   logic [WIDTH-1:0] result_q, result_nxt;
   logic [4:0]       cnt, cnt_nxt;
   logic             sel;
   logic [WIDTH-1:0] xa, xb;
   logic [2:0]       xctrl;
   logic [WIDTH:0]   s;
   logic             qbit, mc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         hi       <= '0;
         lo       <= '0;
         dvsr     <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else begin
         state    <= state_nxt;
         op_q     <= op_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
         dvsr     <= dvsr_nxt;
         cnt      <= cnt_nxt;
         result_q <= result_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      op_nxt     = op_q;
      hi_nxt     = hi;
      lo_nxt     = lo;
      dvsr_nxt   = dvsr;
      cnt_nxt    = cnt;
      result_nxt = result_q;
      sel        = 1'b0;
      xa         = '0;
      xb         = '0;
      xctrl      = ALU_ADD;
      s          = {hi, lo[WIDTH-1]};
      qbit       = s[WIDTH] | ~bus.alu_carry;
      // carry out of hi + mcand, recovered from wraparound
      mc         = bus.alu_result < hi;
      case (state)
         IDLE: begin
            if (bus.start) begin
               op_nxt   = bus.op;
               dvsr_nxt = bus.b;
               hi_nxt   = '0;
               lo_nxt   = bus.a;
               cnt_nxt  = '0;
               if (bus.op[1] && bus.b == '0) begin
                  state_nxt  = DONE;
                  result_nxt = (bus.op == MD_DIVU) ? '1 : bus.a;
               end else begin
                  state_nxt  = CALC;
               end
            end
         end
         CALC: begin
            sel     = 1'b1;
            xb      = dvsr;
            cnt_nxt = cnt + 5'd1;
            if (!op_q[1]) begin
               xa    = hi;
               xctrl = ALU_ADD;
               if (lo[0]) begin
                  hi_nxt = {mc, bus.alu_result[WIDTH-1:1]};
                  lo_nxt = {bus.alu_result[0], lo[WIDTH-1:1]};
               end else begin
                  hi_nxt = {1'b0, hi[WIDTH-1:1]};
                  lo_nxt = {hi[0], lo[WIDTH-1:1]};
               end
            end else begin
               xa     = s[WIDTH-1:0];
               xctrl  = ALU_SUB;
               hi_nxt = qbit ? bus.alu_result : s[WIDTH-1:0];
               lo_nxt = {lo[WIDTH-2:0], qbit};
            end
            if (cnt == 5'd31) begin
               state_nxt  = DONE;
               result_nxt = md_pick(op_q, hi_nxt, lo_nxt);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.result    = result_q;
   assign bus.alu_sel   = sel;
   assign bus.alu_a     = xa;
   assign bus.alu_b     = xb;
   assign bus.alu_ctrl  = xctrl;
   assign bus.alu_op7b5 = 1'b0;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU, the alu_sel mux and
// a cycle-level arithmetic reference model.
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   alu_muldiv_seq_if bus ();
   alu_muldiv_seq dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // shared ALU behind the alu_sel mux; the core datapath side is idle (zeros)
   logic [31:0] x_a, x_b;
   logic [2:0]  x_ctrl;
   always_comb begin
      x_a            = bus.alu_sel ? bus.alu_a : 32'd0;
      x_b            = bus.alu_sel ? bus.alu_b : 32'd0;
      x_ctrl         = bus.alu_sel ? bus.alu_ctrl : ALU_ADD;
      bus.alu_result = (x_ctrl == ALU_SUB) ? x_a - x_b : x_a + x_b;
      bus.alu_carry  = (x_ctrl == ALU_SUB) && (x_a < x_b);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      p = 64'(x) * 64'(y);
      case (o)
         MD_MUL:   ref_md = p[31:0];
         MD_MULHU: ref_md = p[63:32];
         MD_DIVU:  ref_md = (y == 0) ? 32'hFFFF_FFFF : x / y;
         default:  ref_md = (y == 0) ? x : x % y;
      endcase
   endfunction

   // reference model: cycles remaining to done, pending answer, visible result
   int          m_left;
   bit          m_done;
   logic [31:0] m_pend, m_result;
   logic [1:0]  m_op;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left <= 0; m_done <= 0; m_pend <= 0; m_result <= 0; m_op <= 0;
      end else if (m_done) begin
         m_done <= 0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done   <= 1;
            m_result <= m_pend;
         end
      end else if (bus.start) begin
         m_op <= bus.op;
         if (bus.op[1] && bus.b == 0) begin
            m_done   <= 1;
            m_result <= ref_md(bus.op, bus.a, bus.b);
         end else begin
            m_left <= 32;
            m_pend <= ref_md(bus.op, bus.a, bus.b);
         end
      end
   end

   bit run_chk = 0;
   always @(negedge clk) begin
      if (run_chk && !reset) begin
         chk("busy", 32'(bus.busy), 32'(m_left > 0 || m_done));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("alu_sel", 32'(bus.alu_sel), 32'(m_left > 0));
         chk("result", bus.result, m_result);
         chk("alu_op7b5", 32'(bus.alu_op7b5), 32'd0);
         if (m_left > 0) begin
            chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_op[1] ? ALU_SUB : ALU_ADD));
         end else begin
            chk("idle_alu", {bus.alu_a | bus.alu_b}, 32'd0);
            chk("idle_ctrl", 32'(bus.alu_ctrl), 32'd0);
         end
      end
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat, input string nm, input bit glitch);
      bit got;
      int nbusy;
      @(posedge clk); #1;
      bus.start = 1; bus.op = o; bus.a = x; bus.b = y;
      @(posedge clk); #1;
      bus.start = 0;
      got = 0; nbusy = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (glitch && k == 5) begin
            bus.start = 1; bus.op = MD_DIVU; bus.a = 32'd1; bus.b = 32'd1;
         end
         if (glitch && k == 7) bus.start = 0;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            got = 1;
            chk({nm, " latency"}, 32'(k), 32'(lat));
            chk({nm, " busy_cycles"}, 32'(nbusy), 32'(lat));
            chk(nm, bus.result, exp);
         end
      end
      if (!got) chk({nm, " timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      chk({nm, " done_width"}, 32'(bus.done), 32'd0);
      chk({nm, " hold"}, bus.result, exp);
   endtask

   initial begin
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
      #12;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst result", bus.result, 32'd0);
      chk("rst alu_sel", 32'(bus.alu_sel), 32'd0);
      chk("rst alu_a", bus.alu_a, 32'd0);
      @(negedge clk); reset = 0; run_chk = 1;

      run_op(MD_MUL,   32'd7,          32'd6,          32'd42,         33, "mul 7x6", 0);
      run_op(MD_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, "mul max", 0);
      run_op(MD_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, "mulhu max", 0);
      run_op(MD_DIVU,  32'd100,        32'd7,          32'd14,         33, "divu 100/7", 0);
      run_op(MD_REMU,  32'd100,        32'd7,          32'd2,          33, "remu 100/7", 0);
      run_op(MD_DIVU,  32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          33, "divu s32", 0);
      run_op(MD_REMU,  32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33, "remu s32", 0);
      run_op(MD_DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu by0", 0);
      run_op(MD_REMU,  32'd5,          32'd0,          32'd5,          1,  "remu by0", 0);
      run_op(MD_MULHU, 32'h1234_5678,  32'h0001_0000,  32'h0000_1234,  33, "mulhu shift", 0);
      run_op(MD_MUL,   32'd7,          32'd6,          32'd42,         33, "mul busy start", 1);

      // reset in the middle of a multiply
      @(posedge clk); #1;
      bus.start = 1; bus.op = MD_MUL; bus.a = 32'd9; bus.b = 32'd9;
      @(posedge clk); #1;
      bus.start = 0;
      repeat (10) @(posedge clk);
      #1 reset = 1;
      #1;
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst result", bus.result, 32'd0);
      chk("midrst alu_sel", 32'(bus.alu_sel), 32'd0);
      @(negedge clk); reset = 0;
      run_op(MD_MUL, 32'd3, 32'd5, 32'd15, 33, "mul 3x5", 0);

      run_chk = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
